bcd_cascade_counter: RTL and testbench

Parametrised multi-digit decade counter. It is the successor to the single-digit 4-bit 2421 decade counter.
- DIGITS cascaded decimal digits; counts up or down.
- Synchronous parallel load.
- Per-cycle selectable output code: 8421, 2421 (Aiken) or excess-3.
- Carry/borrow output for chaining counters.
- Used as the display/event counter in lab datapaths, driving 7-segment decoders or feeding further counter stages.

---
 rtl/bcd_cascade_pkg.sv | 21 ++
 rtl/bcd_digit_cell.sv | 46 ++++
 rtl/bcd_cascade_counter.sv | 83 ++++++++
 tb/tb_bcd_cascade_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_cascade_pkg.sv
// Shared constants and the per-digit output encoder for the BCD cascade counter.
package bcd_cascade_pkg;

  localparam logic [1:0] CODE_8421 = 2'd0;
  localparam logic [1:0] CODE_2421 = 2'd1;
  localparam logic [1:0] CODE_XS3  = 2'd2;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Encode one decimal digit (0..9) in the selected code; code 3 falls back to 8421.
  function automatic logic [3:0] encode_digit(input logic [3:0] d, input logic [1:0] code);
    logic [3:0] enc;
    case (code)
      CODE_2421: enc = (d > 4'd4) ? 4'(d + 4'd6) : d;
      CODE_XS3:  enc = 4'(d + 4'd3);
      default:   enc = d;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade digit: holds 0..9, steps up/down, sanitises parallel-load nibbles.
module bcd_digit_cell
  import bcd_cascade_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_in,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_nib,
  output logic [3:0] d,
  output logic       term,
  output logic       invalid
);

  logic [3:0] d_q, d_d;

  assign invalid = (load_nib > DIGIT_MAX);
  // Terminal digit for the current direction enables the next digit up the chain.
  assign term    = up ? (d_q == DIGIT_MAX) : (d_q == 4'd0);
  assign d       = d_q;

  // Next-digit value: load beats step; invalid nibbles load as zero.
  always_comb begin
    d_d = d_q;
    if (load) begin
      d_d = invalid ? 4'd0 : load_nib;
    end else if (step_in) begin
      if (up) begin
        d_d = (d_q == DIGIT_MAX) ? 4'd0 : 4'(d_q + 4'd1);
      end else begin
        d_d = (d_q == 4'd0) ? DIGIT_MAX : 4'(d_q - 4'd1);
      end
    end
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= 4'd0;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit up/down decade counter with parallel load, selectable output code and carry.
module bcd_cascade_counter
  import bcd_cascade_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [1:0]            code_sel,
  output logic [4*DIGITS-1:0]   z,
  output logic                  carry,
  output logic                  wrapped,
  output logic                  load_err
);

  logic [3:0]      d [DIGITS];
  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] invalid;
  // chain[i] is high when x is set and every digit below i is terminal.
  logic [DIGITS:0]   chain;

  logic wrapped_q, wrapped_d;
  logic load_err_q, load_err_d;

  assign chain[0] = x;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign chain[i+1] = chain[i] & term[i];

    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .step_in  (chain[i]),
      .up       (up),
      .load     (load),
      .load_nib (load_val[4*i +: 4]),
      .d        (d[i]),
      .term     (term[i]),
      .invalid  (invalid[i])
    );
  end

  // chain[DIGITS] means every digit is terminal and counting is enabled.
  assign carry    = rst & ~load & chain[DIGITS];
  assign wrapped  = wrapped_q;
  assign load_err = load_err_q;

  // Encode every digit in the selected code; purely combinational.
  always_comb begin
    z = '0;
    for (int i = 0; i < DIGITS; i++) begin
      z[4*i +: 4] = encode_digit(d[i], code_sel);
    end
  end

  // Sticky wrap flag and one-cycle load-error flag.
  always_comb begin
    wrapped_d  = wrapped_q;
    load_err_d = 1'b0;
    if (load) begin
      wrapped_d  = 1'b0;
      load_err_d = |invalid;
    end else if (chain[DIGITS]) begin
      wrapped_d = 1'b1;
    end
  end

  // Status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench: 2-digit counter plus a chained pair of 1-digit counters vs. a model.
module tb_bcd_cascade_counter;

  logic       clk;
  logic       rst;
  logic       x;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [1:0] code_sel;
  logic [7:0] z;
  logic       carry, wrapped, load_err;

  logic [3:0] z_lo, z_hi;
  logic       c_lo, c_hi, w_lo, w_hi, e_lo, e_hi;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: counter value as a plain integer 0..99.
  int   m_v   = 0;
  logic m_w   = 1'b0;
  logic m_e   = 1'b0;
  logic exp_c;
  logic obs_c;

  bcd_cascade_counter #(.DIGITS(2)) dut (
    .clk(clk), .rst(rst), .x(x), .up(up), .load(load), .load_val(load_val),
    .code_sel(code_sel), .z(z), .carry(carry), .wrapped(wrapped), .load_err(load_err)
  );

  bcd_cascade_counter #(.DIGITS(1)) u_lo (
    .clk(clk), .rst(rst), .x(x), .up(up), .load(load), .load_val(load_val[3:0]),
    .code_sel(code_sel), .z(z_lo), .carry(c_lo), .wrapped(w_lo), .load_err(e_lo)
  );

  bcd_cascade_counter #(.DIGITS(1)) u_hi (
    .clk(clk), .rst(rst), .x(c_lo), .up(up), .load(load), .load_val(load_val[7:4]),
    .code_sel(code_sel), .z(z_hi), .carry(c_hi), .wrapped(w_hi), .load_err(e_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] enc(input int dig, input logic [1:0] cs);
    if (cs == 2'd1) return 4'((dig < 5) ? dig : dig + 6);
    if (cs == 2'd2) return 4'(dig + 3);
    return 4'(dig);
  endfunction

  function automatic logic [7:0] exp_z(input int v, input logic [1:0] cs);
    return {enc(v / 10, cs), enc(v % 10, cs)};
  endfunction

  // Apply one clock of stimulus; snapshot carry mid-cycle, then advance the model.
  task automatic drive_cycle(input logic r, input logic l, input logic [7:0] lv,
                             input logic xv, input logic uv, input logic [1:0] cs);
    int lo, hi;
    rst = r; load = l; load_val = lv; x = xv; up = uv; code_sel = cs;
    exp_c = r & ~l & xv & (uv ? (m_v == 99) : (m_v == 0));
    @(negedge clk);
    obs_c = carry;
    @(posedge clk);
    if (!r) begin
      m_v = 0; m_w = 1'b0; m_e = 1'b0;
    end else if (l) begin
      lo  = (lv[3:0] > 9) ? 0 : int'(lv[3:0]);
      hi  = (lv[7:4] > 9) ? 0 : int'(lv[7:4]);
      m_e = (lv[3:0] > 9) || (lv[7:4] > 9);
      m_v = hi * 10 + lo;
      m_w = 1'b0;
    end else begin
      m_e = 1'b0;
      if (xv) begin
        if (uv) begin
          if (m_v == 99) m_w = 1'b1;
          m_v = (m_v + 1) % 100;
        end else begin
          if (m_v == 0) m_w = 1'b1;
          m_v = (m_v + 99) % 100;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1);
    n_vec++; if (z !== 8'h00) begin n_bad++; $display("FAIL reset_z got=%h want=00", z); end
    n_vec++; if (obs_c !== 1'b0) begin n_bad++; $display("FAIL reset_carry got=%b want=0", obs_c); end
    n_vec++; if (wrapped !== 1'b0) begin n_bad++; $display("FAIL reset_wrapped got=%b want=0", wrapped); end
    n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_load_err got=%b want=0", load_err); end
    code_sel = 2'd2; #1;
    n_vec++; if (z !== 8'h33) begin n_bad++; $display("FAIL reset_z_xs3 got=%h want=33", z); end
  endtask

  task automatic test_count_up();
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1);
      n_vec++;
      if (z !== exp_z(m_v, 2'd1)) begin
        n_bad++; $display("FAIL count_up_z step=%0d got=%h want=%h", i, z, exp_z(m_v, 2'd1));
      end
      if (i == 7) begin
        n_vec++; if (z !== 8'b0000_1101) begin n_bad++; $display("FAIL count_7_2421 got=%b want=00001101", z); end
      end
    end
    n_vec++; if (z !== 8'b0001_0010) begin n_bad++; $display("FAIL count_12_2421 got=%b want=00010010", z); end
  endtask

  task automatic test_wrap_up();
    drive_cycle(1'b1, 1'b1, 8'h98, 1'b1, 1'b1, 2'd0);
    n_vec++; if (z !== 8'h98) begin n_bad++; $display("FAIL wrap_up_load got=%h want=98", z); end
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0);
    n_vec++; if (z !== 8'h99) begin n_bad++; $display("FAIL wrap_up_99 got=%h want=99", z); end
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0);
    n_vec++; if (obs_c !== 1'b1) begin n_bad++; $display("FAIL wrap_up_carry got=%b want=1", obs_c); end
    n_vec++; if (z !== 8'h00 || wrapped !== 1'b1) begin
      n_bad++; $display("FAIL wrap_up_00 got=%h/%b want=00/1", z, wrapped);
    end
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0);
    n_vec++; if (z !== 8'h01 || wrapped !== 1'b1) begin
      n_bad++; $display("FAIL wrap_up_01 got=%h/%b want=01/1", z, wrapped);
    end
  endtask

  task automatic test_wrap_down();
    drive_cycle(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 2'd0);
    n_vec++; if (z !== 8'h01 || wrapped !== 1'b0) begin
      n_bad++; $display("FAIL down_load got=%h/%b want=01/0", z, wrapped);
    end
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0);
    n_vec++; if (z !== 8'h00) begin n_bad++; $display("FAIL down_00 got=%h want=00", z); end
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0);
    n_vec++; if (obs_c !== 1'b1) begin n_bad++; $display("FAIL down_carry got=%b want=1", obs_c); end
    n_vec++; if (z !== 8'h99 || wrapped !== 1'b1) begin
      n_bad++; $display("FAIL down_99 got=%h/%b want=99/1", z, wrapped);
    end
    code_sel = 2'd2; #1;
    n_vec++; if (z !== 8'hCC) begin n_bad++; $display("FAIL down_xs3 got=%h want=CC", z); end
    code_sel = 2'd3; #1;
    n_vec++; if (z !== 8'h99 || wrapped !== 1'b1) begin
      n_bad++; $display("FAIL code3_as_8421 got=%h/%b want=99/1", z, wrapped);
    end
  endtask

  task automatic test_load_err();
    drive_cycle(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 2'd0);
    n_vec++; if (z !== 8'h05 || load_err !== 1'b1) begin
      n_bad++; $display("FAIL load_err_set got=%h/%b want=05/1", z, load_err);
    end
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0);
    n_vec++; if (z !== 8'h05 || load_err !== 1'b0) begin
      n_bad++; $display("FAIL load_err_clear got=%h/%b want=05/0", z, load_err);
    end
    drive_cycle(1'b1, 1'b1, 8'h4F, 1'b1, 1'b0, 2'd0);
    n_vec++; if (z !== 8'h40 || load_err !== 1'b1) begin
      n_bad++; $display("FAIL load_x_ignored got=%h/%b want=40/1", z, load_err);
    end
  endtask

  task automatic test_rst_override();
    drive_cycle(1'b1, 1'b1, 8'h57, 1'b1, 1'b1, 2'd0);
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0);
    drive_cycle(1'b0, 1'b1, 8'hA9, 1'b1, 1'b1, 2'd0);
    n_vec++; if (z !== 8'h00 || wrapped !== 1'b0 || load_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_override got=%h/%b/%b want=00/0/0", z, wrapped, load_err);
    end
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0);
    n_vec++; if (z !== 8'h01) begin n_bad++; $display("FAIL rst_resume got=%h want=01", z); end
  endtask

  task automatic test_chain();
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'(i % 3));
      for (int c = 0; c < 3; c++) begin
        code_sel = 2'(c); #1;
        n_vec++;
        if ({z_hi, z_lo} !== exp_z(m_v, code_sel) || z !== exp_z(m_v, code_sel)) begin
          n_bad++;
          $display("FAIL chain i=%0d code=%0d chain=%h single=%h want=%h",
                   i, c, {z_hi, z_lo}, z, exp_z(m_v, code_sel));
        end
      end
    end
  endtask

  task automatic test_random();
    logic r, l, xv, uv;
    logic [7:0] lv;
    logic [1:0] cs;
    uv = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 29) != 0);
      l  = ($urandom_range(0, 9) == 0);
      xv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) uv = ~uv;
      lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
      if ($urandom_range(0, 2) == 0) lv = 8'h99 - 8'($urandom_range(0, 1));
      cs = 2'($urandom_range(0, 3));
      drive_cycle(r, l, lv, xv, uv, cs);
      n_vec++;
      if (obs_c !== exp_c || z !== exp_z(m_v, cs) || {z_hi, z_lo} !== exp_z(m_v, cs) ||
          wrapped !== m_w || load_err !== m_e) begin
        n_bad++;
        $display("FAIL random i=%0d z=%h chain=%h c=%b w=%b e=%b want z=%h c=%b w=%b e=%b",
                 i, z, {z_hi, z_lo}, obs_c, wrapped, load_err, exp_z(m_v, cs), exp_c, m_w, m_e);
      end
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_val = 8'h00; x = 1'b0; up = 1'b1; code_sel = 2'd0;
    @(posedge clk); #1;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_load_err();
    test_rst_override();
    test_chain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
